cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/halt/single-step and reset sequencer for the JAM-1 CPU core.
- Sits between the board buttons and the CPU pipeline.
- Drives the CPU clock-enable and the pipeline reset.
- After any reset, holds the pipeline in reset with the clock enabled for a fixed number of cycles so every stage flushes. It then releases the CPU into RUN or HALT and gates execution from debounced front-panel buttons and the CPU halt request.

Parameters:
- RST_CYCLES, 8: cycles cpu_reset_n is held low, with cpu_clk_en high, after any reset (minimum 1).
- RST_W, 4: width of the reset-hold counter; must hold RST_CYCLES-1.
- DEB_BITS, 4: debounce counter width; an input must be stable for 2^DEB_BITS cycles to be accepted.
- START_RUN, 1: 1 = enter RUN after reset hold, 0 = enter HALT.

Ports:
- clk, input, 1: system clock.
- reset_in_n, input, 1: asynchronous active-low reset.
- btn_run_n, input, 1: raw run/halt toggle button, active-low, asynchronous.
- btn_step_n, input, 1: raw single-step button, active-low, asynchronous.
- soft_reset_n, input, 1: synchronous active-low reset request from the bus/IO.
- halt_req, input, 1: CPU halt request (HLT opcode), synchronous level.
- cpu_clk_en, output, 1: CPU clock enable.
- cpu_reset_n, output, 1: CPU pipeline reset, active-low.
- running, output, 1: high in RUN.
- halted, output, 1: high in HALT.
- cycle_count, output, 16: enabled-cycle counter (optional feature).

Behaviour:
- One clock, clk. reset_in_n is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state = RST_HOLD, counter = RST_CYCLES-1
  - cpu_reset_n = 0, cpu_clk_en = 1
  - running = 0, halted = 0
  - synchronizers = 1, debounced levels = 1 (released), halt_req edge register = 0.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter: resets whenever the synced input equals the debounced level; otherwise increments. At all-ones, the debounced level takes the synced value and the counter clears.
  - A press is a single-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- halt_req event = rising edge (registered previous value). A level held high does not re-halt after a run press.
- States: RST_HOLD, RUN, HALT, STEP.
- RST_HOLD:
  - Counter decrements each cycle.
  - When the counter is 0, go to RUN if START_RUN=1, else HALT.
  - cpu_reset_n goes high on the same edge the state leaves RST_HOLD, so it is low for exactly RST_CYCLES cycles.
  - Presses and halt events are ignored.
- RUN:
  - A halt_req event or a run press -> HALT.
  - A step press is ignored.
- HALT:
  - A run press -> RUN.
  - Else a step press -> STEP.
  - A simultaneous run press and step press resolves to RUN.
- STEP: unconditionally -> HALT next cycle. A halt_req event in STEP is consumed with no further effect.
- Output decode from state:
  - cpu_clk_en = 1 in RST_HOLD, RUN and STEP.
  - running = (state == RUN).
  - halted = (state == HALT).
  - cpu_clk_en is high for exactly one cycle per accepted step press.
- Priority in every state: reset_in_n > soft_reset_n low > halt_req event > run press > step press.
- soft_reset_n low in any state, including mid-RST_HOLD, reloads the counter to RST_CYCLES-1 and enters RST_HOLD on the next edge. The hold restarts fully.
- Latency, raw button edge to state change: 2 synchronizer cycles + 2^DEB_BITS debounce cycles + 1 cycle.

Optional Feature:
- Macro: CYCLE_COUNT_EN.
- Defined:
  - cycle_count is a 16-bit counter, incremented on every cycle where cpu_clk_en=1 and cpu_reset_n=1.
  - Wraps 0xFFFF->0x0000.
  - Cleared by reset_in_n and by entry into RST_HOLD.
- Undefined: cycle_count is tied to 16'h0000 and no counter flops exist.

Decomposition:
- Shared package jam1_ctrl_pkg holds:
  - the state encoding (2-bit localparams ST_RST_HOLD=0, ST_RUN=1, ST_HALT=2, ST_STEP=3)
  - the CYCLE_COUNT width constant (16).
- One sub-module, btn_debounce (synchronizer + debounce + press pulse, parameter DEB_BITS), instantiated twice.

Test Plan (DEB_BITS=2, RST_CYCLES=8, START_RUN=1 unless stated):
- Power-on: release reset_in_n -> cpu_reset_n low for exactly 8 cycles with cpu_clk_en=1, then cpu_reset_n=1 and running=1.
- Bouncy step button in HALT (START_RUN=0): btn_step_n toggling every cycle for 10 cycles, then held low -> no step during the bounce; exactly one cpu_clk_en=1 cycle 2+4+1 cycles after the stable low; halted returns to 1.
- halt_req pulse in RUN -> halted=1 and cpu_clk_en=0 next state cycle. halt_req held high, then a run press -> RUN and stays running.
- Simultaneous run press and step press in HALT -> RUN; no STEP cycle observed.
- soft_reset_n low for 1 cycle at cycle 4 of RST_HOLD -> hold restarts; cpu_reset_n low a full 8 cycles after the request.
- CYCLE_COUNT_EN: 3 step presses after power-on into HALT -> cycle_count=3. Force 0xFFFF in RUN -> wraps to 0x0000.

Source files
------------

// File: rtl/jam1_ctrl_pkg.sv
// jam1_ctrl_pkg: shared run-controller state encoding and cycle counter width for JAM-1
package jam1_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALT     = 2'd2,
    ST_STEP     = 2'd3
  } state_t;
  localparam int CYCLE_COUNT_W = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debounce and registered press pulse for an active-low button
module btn_debounce #(
  parameter int DEB_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);
  logic                s1_q, s2_q, deb_q, deb_d, press_q, press_d, flip;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;
  always_comb begin
    flip    = (s2_q != deb_q) && (&cnt_q);
    deb_d   = flip ? s2_q : deb_q;
    cnt_d   = (s2_q == deb_q || flip) ? '0 : cnt_q + 1'b1;
    press_d = deb_q & ~deb_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_n;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: JAM-1 run/halt/step/reset sequencer driving cpu_clk_en and cpu_reset_n; define CYCLE_COUNT_EN for the 16-bit enabled-cycle counter
module cpu_run_ctrl
  import jam1_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 8,
  parameter int RST_W      = 4,
  parameter int DEB_BITS   = 4,
  parameter int START_RUN  = 1
) (
  input  logic                     clk,
  input  logic                     reset_in_n,
  input  logic                     btn_run_n,
  input  logic                     btn_step_n,
  input  logic                     soft_reset_n,
  input  logic                     halt_req,
  output logic                     cpu_clk_en,
  output logic                     cpu_reset_n,
  output logic                     running,
  output logic                     halted,
  output logic [CYCLE_COUNT_W-1:0] cycle_count
);
  state_t             state_q, state_d;
  logic [RST_W-1:0]   cnt_q, cnt_d;
  logic               halt_prev_q, halt_ev, run_press, step_press;
  logic               cpu_clk_en_q, cpu_clk_en_d, cpu_reset_n_q, cpu_reset_n_d;
  logic               running_q, running_d, halted_q, halted_d;
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_run (
    .clk(clk), .rst_n(reset_in_n), .btn_n(btn_run_n), .press(run_press)
  );
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_step (
    .clk(clk), .rst_n(reset_in_n), .btn_n(btn_step_n), .press(step_press)
  );
  assign halt_ev = halt_req & ~halt_prev_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!soft_reset_n) begin
      state_d = ST_RST_HOLD;
      cnt_d   = RST_W'(RST_CYCLES - 1);
    end else if (state_q == ST_RST_HOLD) begin
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      state_d = (cnt_q != '0) ? ST_RST_HOLD : (START_RUN != 0) ? ST_RUN : ST_HALT;
    end else if (state_q == ST_STEP || halt_ev) begin
      state_d = ST_HALT;
    end else if (run_press) begin
      state_d = (state_q == ST_RUN) ? ST_HALT : ST_RUN;
    end else if (step_press && state_q == ST_HALT) begin
      state_d = ST_STEP;
    end
    cpu_clk_en_d  = state_d != ST_HALT;
    cpu_reset_n_d = state_d != ST_RST_HOLD;
    running_d     = state_d == ST_RUN;
    halted_d      = state_d == ST_HALT;
  end
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q       <= ST_RST_HOLD;
      cnt_q         <= RST_W'(RST_CYCLES - 1);
      halt_prev_q   <= 1'b0;
      cpu_clk_en_q  <= 1'b1;
      cpu_reset_n_q <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      halt_prev_q   <= halt_req;
      cpu_clk_en_q  <= cpu_clk_en_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
    end
  end
  assign cpu_clk_en  = cpu_clk_en_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign running     = running_q;
  assign halted      = halted_q;
`ifdef CYCLE_COUNT_EN
  logic [CYCLE_COUNT_W-1:0] cycle_count_q, cycle_count_d;
  always_comb begin
    cycle_count_d = (state_d == ST_RST_HOLD) ? '0 :
                    (cpu_clk_en_q & cpu_reset_n_q) ? cycle_count_q + 1'b1 : cycle_count_q;
  end
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) cycle_count_q <= '0;
    else cycle_count_q <= cycle_count_d;
  end
  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl with a START_RUN=1 and a START_RUN=0 instance
module tb_cpu_run_ctrl;
`ifdef CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_in_n = 1'b0;
  logic        r_run_n = 1'b1, r_step_n = 1'b1, r_soft_n = 1'b1, r_halt = 1'b0;
  logic        h_run_n = 1'b1, h_step_n = 1'b1, h_soft_n = 1'b1, h_halt = 1'b0;
  logic        r_clk_en, r_rst_n, r_running, r_halted;
  logic        h_clk_en, h_rst_n, h_running, h_halted;
  logic [15:0] r_cc, h_cc;
  logic [3:0]  r_vec, h_vec;
  int          checks = 0;
  int          errors = 0;
  assign r_vec = {r_rst_n, r_clk_en, r_running, r_halted};
  assign h_vec = {h_rst_n, h_clk_en, h_running, h_halted};
  always #5 clk = ~clk;
  cpu_run_ctrl #(.RST_CYCLES(8), .RST_W(4), .DEB_BITS(2), .START_RUN(1)) dut_r (
    .clk(clk), .reset_in_n(reset_in_n), .btn_run_n(r_run_n), .btn_step_n(r_step_n),
    .soft_reset_n(r_soft_n), .halt_req(r_halt), .cpu_clk_en(r_clk_en), .cpu_reset_n(r_rst_n),
    .running(r_running), .halted(r_halted), .cycle_count(r_cc)
  );
  cpu_run_ctrl #(.RST_CYCLES(8), .RST_W(4), .DEB_BITS(2), .START_RUN(0)) dut_h (
    .clk(clk), .reset_in_n(reset_in_n), .btn_run_n(h_run_n), .btn_step_n(h_step_n),
    .soft_reset_n(h_soft_n), .halt_req(h_halt), .cpu_clk_en(h_clk_en), .cpu_reset_n(h_rst_n),
    .running(h_running), .halted(h_halted), .cycle_count(h_cc)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick(3);
    checks++; if (r_vec !== 4'b0100) begin errors++; $display("FAIL reset_r got %b want 0100", r_vec); end
    checks++; if (h_vec !== 4'b0100) begin errors++; $display("FAIL reset_h got %b want 0100", h_vec); end
    checks++; if (r_cc !== 16'h0) begin errors++; $display("FAIL reset_cc got %h want 0000", r_cc); end
    reset_in_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      checks++; if (r_vec !== 4'b0100) begin errors++; $display("FAIL hold_r cycle %0d got %b want 0100", i, r_vec); end
      checks++; if (h_vec !== 4'b0100) begin errors++; $display("FAIL hold_h cycle %0d got %b want 0100", i, h_vec); end
    end
    tick(1);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL release_run got %b want 1110", r_vec); end
    checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL release_halt got %b want 1001", h_vec); end
    checks++; if (h_cc !== 16'h0) begin errors++; $display("FAIL release_cc got %h want 0000", h_cc); end
  endtask
  task automatic test_step_in_run;
    r_step_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL step_in_run cycle %0d got %b want 1110", i, r_vec); end
    end
    r_step_n = 1'b1;
    tick(8);
  endtask
  task automatic test_halt_req;
    r_halt = 1'b1;
    tick(1);
    checks++; if (r_vec !== 4'b1001) begin errors++; $display("FAIL halt_req got %b want 1001", r_vec); end
    r_run_n = 1'b0;
    tick(6);
    checks++; if (r_vec !== 4'b1001) begin errors++; $display("FAIL run_early got %b want 1001", r_vec); end
    tick(1);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL run_press got %b want 1110", r_vec); end
    tick(5);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL halt_level got %b want 1110", r_vec); end
    r_run_n = 1'b1;
    tick(8);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL run_release got %b want 1110", r_vec); end
    r_halt = 1'b0;
    tick(1);
  endtask
  task automatic test_simultaneous;
    r_halt = 1'b1;
    tick(1);
    r_halt = 1'b0;
    checks++; if (r_vec !== 4'b1001) begin errors++; $display("FAIL sim_halt got %b want 1001", r_vec); end
    r_run_n = 1'b0;
    r_step_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++; if (r_vec !== 4'b1001) begin errors++; $display("FAIL sim_wait cycle %0d got %b want 1001", i, r_vec); end
    end
    tick(1);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL sim_run got %b want 1110", r_vec); end
    r_run_n = 1'b1;
    r_step_n = 1'b1;
    tick(8);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL sim_stay got %b want 1110", r_vec); end
  endtask
  task automatic test_bouncy_step;
    for (int i = 0; i < 10; i++) begin
      h_step_n = (i % 2 == 1);
      tick(1);
      checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL bounce cycle %0d got %b want 1001", i, h_vec); end
    end
    h_step_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL step_wait cycle %0d got %b want 1001", i, h_vec); end
    end
    tick(1);
    checks++; if (h_vec !== 4'b1100) begin errors++; $display("FAIL step_cycle got %b want 1100", h_vec); end
    tick(1);
    checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL step_back got %b want 1001", h_vec); end
    checks++; if (h_cc !== (CC_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL step_cc1 got %h want %h", h_cc, CC_EN ? 16'd1 : 16'd0); end
    tick(4);
    checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL step_held got %b want 1001", h_vec); end
    h_step_n = 1'b1;
    tick(8);
  endtask
  task automatic test_steps;
    for (int k = 0; k < 2; k++) begin
      h_step_n = 1'b0;
      tick(7);
      checks++; if (h_vec !== 4'b1100) begin errors++; $display("FAIL steps_on %0d got %b want 1100", k, h_vec); end
      tick(1);
      checks++; if (h_vec !== 4'b1001) begin errors++; $display("FAIL steps_off %0d got %b want 1001", k, h_vec); end
      h_step_n = 1'b1;
      tick(8);
    end
    checks++; if (h_cc !== (CC_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL steps_cc got %h want %h", h_cc, CC_EN ? 16'd3 : 16'd0); end
  endtask
  task automatic test_soft_reset;
    r_soft_n = 1'b0;
    tick(1);
    r_soft_n = 1'b1;
    checks++; if (r_vec !== 4'b0100) begin errors++; $display("FAIL soft_enter got %b want 0100", r_vec); end
    checks++; if (r_cc !== 16'h0) begin errors++; $display("FAIL soft_cc_clear got %h want 0000", r_cc); end
    tick(3);
    r_soft_n = 1'b0;
    tick(1);
    r_soft_n = 1'b1;
    checks++; if (r_vec !== 4'b0100) begin errors++; $display("FAIL soft_again got %b want 0100", r_vec); end
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      checks++; if (r_vec !== 4'b0100) begin errors++; $display("FAIL soft_hold cycle %0d got %b want 0100", i, r_vec); end
    end
    tick(1);
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL soft_release got %b want 1110", r_vec); end
    checks++; if (r_cc !== 16'h0) begin errors++; $display("FAIL soft_cc0 got %h want 0000", r_cc); end
    tick(1);
    checks++; if (r_cc !== (CC_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL soft_cc1 got %h want %h", r_cc, CC_EN ? 16'd1 : 16'd0); end
  endtask
`ifdef CYCLE_COUNT_EN
  task automatic test_wrap;
    tick(16'hFFFE);
    checks++; if (r_cc !== 16'hFFFF) begin errors++; $display("FAIL wrap_top got %h want ffff", r_cc); end
    tick(1);
    checks++; if (r_cc !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", r_cc); end
    checks++; if (r_vec !== 4'b1110) begin errors++; $display("FAIL wrap_run got %b want 1110", r_vec); end
  endtask
`endif
  initial begin
    test_reset();
    test_step_in_run();
    test_halt_req();
    test_simultaneous();
    test_bouncy_step();
    test_steps();
    test_soft_reset();
`ifdef CYCLE_COUNT_EN
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
